// File: rtl/adder_seq_ctrl.sv
// Operand sequencer and result-capture stage around an external 8-bit ripple-carry adder.
// Optional build macro ADD_SATURATE_EN: saturate the accumulator on signed overflow instead of wrapping.
module adder_seq_ctrl #(
  parameter int unsigned SETTLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  input  logic       in_last,
  output logic [7:0] add_a,
  output logic [7:0] add_b,
  input  logic [7:0] add_s,
  input  logic       add_ovf,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_sum,
  output logic       out_ovf,
  output logic [7:0] out_count
);

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    OUT
  } state_t;

  localparam logic [3:0] CNT_INIT = 4'(SETTLE_CYCLES - 1);

  state_t     state;
  state_t     state_nx;
  logic [7:0] acc;
  logic [7:0] opb;
  logic [7:0] count;
  logic [3:0] cnt;
  logic       last_q;
  logic       ovf_q;
  logic       accept;
  logic       capture;
  logic       consume;
  logic [7:0] acc_cap;

  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    capture  = 1'b0;
    consume  = 1'b0;
    case (state)
      IDLE: begin
        if (in_valid) begin
          accept   = 1'b1;
          state_nx = SETTLE;
        end
      end
      SETTLE: begin
        if (cnt == '0) begin
          capture  = 1'b1;
          state_nx = last_q ? OUT : IDLE;
        end
      end
      OUT: begin
        if (out_ready) begin
          consume  = 1'b1;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

`ifdef ADD_SATURATE_EN
  // Overflow direction follows the sign of A: both operands share it when overflow occurs.
  always_comb begin
    acc_cap = add_s;
    if (add_ovf) acc_cap = add_a[7] ? 8'h80 : 8'h7F;
  end
`else
  always_comb begin
    acc_cap = add_s;
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      acc    <= '0;
      opb    <= '0;
      count  <= '0;
      cnt    <= '0;
      last_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      state <= state_nx;
      if (accept) begin
        opb    <= in_data;
        last_q <= in_last;
        cnt    <= CNT_INIT;
      end else if (state == SETTLE && cnt != '0) begin
        cnt <= cnt - 4'd1;
      end
      if (capture) begin
        acc   <= acc_cap;
        ovf_q <= ovf_q | add_ovf;
        if (count != '1) count <= count + 8'd1;
      end
      if (consume) begin
        acc   <= '0;
        opb   <= '0;
        ovf_q <= 1'b0;
        count <= '0;
      end
    end
  end

  // in_ready is gated by rst_n so it reads low for the whole reset window.
  assign in_ready  = rst_n && (state == IDLE);
  assign out_valid = (state == OUT);
  assign add_a     = acc;
  assign add_b     = opb;
  assign out_sum   = acc;
  assign out_ovf   = ovf_q;
  assign out_count = count;

endmodule
